// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data access.
// Data side wins by default; a starvation counter forces an instruction grant.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    INST,
    DATA_RD
  } owner_e;

  owner_e        owner;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   inst_hold;
  logic [31:0]   data_hold;
  logic          starved;
  logic          inst_win;
  logic          data_win;

  assign starved  = (starve_cnt == CW'(STARVE_LIMIT));

  // Grants are gated by reset so nothing reaches the SRAM while held in reset.
  assign inst_win = resetn & inst_req & (~data_req | starved);
  assign data_win = resetn & data_req & ~inst_win;

  assign inst_gnt = inst_win;
  assign data_gnt = data_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      inst_win: begin
        mem_en   = 1'b1;
        mem_addr = inst_addr;
      end
      data_win: begin
        mem_en    = 1'b1;
        mem_wen   = data_wen;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  assign inst_rvalid = (owner == INST);
  assign data_rvalid = (owner == DATA_RD);

  // SRAM data is passed straight through in the response cycle, then held.
  assign inst_rdata  = inst_rvalid ? mem_rdata : inst_hold;
  assign data_rdata  = data_rvalid ? mem_rdata : data_hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner      <= IDLE;
      starve_cnt <= '0;
      inst_hold  <= '0;
      data_hold  <= '0;
    end else begin
      if (inst_win)
        owner <= INST;
      else if (data_win && data_wen == 4'h0)
        owner <= DATA_RD;
      else
        owner <= IDLE;

      if (inst_rvalid)
        inst_hold <= mem_rdata;
      if (data_rvalid)
        data_hold <= mem_rdata;

      if (inst_win || !inst_req)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, hand sequences and
// random traffic against a shadow-memory reference model.
module tb_sram_port_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  sram_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM, 256 words, 1-cycle read latency
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen == 4'h0)
        mem_rdata <= sram[mem_addr[9:2]];
      else
        for (int b = 0; b < 4; b++)
          if (mem_wen[b])
            sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dw,
                       input logic [31:0] da, input logic [31:0] dd);
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wen   = dw;
    data_addr  = da;
    data_wdata = dd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [3:0]  dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        igt;
    logic        dgt;
    logic [3:0]  mwen;
    logic        irv;
    logic [31:0] ird;
    logic        drv;
    logic [31:0] drd;
  } vec_t;

  vec_t tv [11];

  // reference model state
  logic [31:0] shadow [256];
  int          m_cnt;
  bit          m_pi, m_pd;
  logic [31:0] m_piv, m_pdv, m_hi, m_hd;
  bit          r_ir, r_dr;
  logic [31:0] r_ia, r_da, r_dd;
  logic [3:0]  r_dw;

  initial begin
    bit          pat [8];
    bit          ew_i, ew_d;
    logic [31:0] w;

    for (int i = 0; i < 256; i++)
      sram[i] = 32'hC0DE0000 | 32'(i);
    sram[8'h40] = 32'hDEADBEEF;
    sram[8'h00] = 32'hA0A0A0A0;
    sram[8'h01] = 32'hB1B1B1B1;

    tv[0]  = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0,
               1'b1, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
               1'b0, 1'b0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
               1'b0, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[3]  = '{1'b1, 32'h100, 1'b1, 4'hF, 32'h200, 32'h12345678,
               1'b0, 1'b1, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0,
               1'b0, 1'b1, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[5]  = '{1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
               1'b1, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h12345678};
    tv[6]  = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0,
               1'b0, 1'b1, 4'h0, 1'b1, 32'hA0A0A0A0, 1'b0, 32'h12345678};
    tv[7]  = '{1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0,
               1'b1, 1'b0, 4'h0, 1'b0, 32'hA0A0A0A0, 1'b1, 32'hB1B1B1B1};
    tv[8]  = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0,
               1'b0, 1'b1, 4'h0, 1'b1, 32'hB1B1B1B1, 1'b0, 32'hB1B1B1B1};
    tv[9]  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
               1'b0, 1'b0, 4'h0, 1'b0, 32'hB1B1B1B1, 1'b1, 32'hA0A0A0A0};
    tv[10] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
               1'b0, 1'b0, 4'h0, 1'b0, 32'hB1B1B1B1, 1'b0, 32'hA0A0A0A0};

    // reset state with both requesters active
    drive(1, 32'h100, 1, 4'hF, 32'h200, 32'h55);
    #3;
    chk("rst_inst_gnt", 32'(inst_gnt), 0);
    chk("rst_data_gnt", 32'(data_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_wen", 32'(mem_wen), 0);
    chk("rst_inst_rvalid", 32'(inst_rvalid), 0);
    chk("rst_data_rvalid", 32'(data_rvalid), 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    do_reset();

    // vector table
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      drive(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd);
      #3;
      chk($sformatf("v%0d_inst_gnt", i), 32'(inst_gnt), 32'(tv[i].igt));
      chk($sformatf("v%0d_data_gnt", i), 32'(data_gnt), 32'(tv[i].dgt));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en),
          32'(tv[i].igt | tv[i].dgt));
      chk($sformatf("v%0d_mem_wen", i), 32'(mem_wen), 32'(tv[i].mwen));
      if (tv[i].igt | tv[i].dgt)
        chk($sformatf("v%0d_mem_addr", i), mem_addr,
            tv[i].igt ? tv[i].ia : tv[i].da);
      chk($sformatf("v%0d_inst_rvalid", i), 32'(inst_rvalid),
          32'(tv[i].irv));
      chk($sformatf("v%0d_inst_rdata", i), inst_rdata, tv[i].ird);
      chk($sformatf("v%0d_data_rvalid", i), 32'(data_rvalid),
          32'(tv[i].drv));
      chk($sformatf("v%0d_data_rdata", i), data_rdata, tv[i].drd);
    end

    // both requesting continuously: D,D,D,I repeating
    do_reset();
    pat = '{1, 1, 1, 0, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1, 32'h4, 1, 4'h0, 32'h0, 32'h0);
      #3;
      chk($sformatf("starve%0d_data_gnt", i), 32'(data_gnt), 32'(pat[i]));
      chk($sformatf("starve%0d_inst_gnt", i), 32'(inst_gnt), 32'(!pat[i]));
      chk($sformatf("starve%0d_onehot", i), 32'(inst_gnt & data_gnt), 0);
    end

    // reset right after an instruction grant drops the response
    do_reset();
    @(posedge clk); #1;
    drive(1, 32'h100, 0, 0, 0, 0);
    #3;
    chk("rmid_inst_gnt", 32'(inst_gnt), 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("rmid_inst_rvalid", 32'(inst_rvalid), 0);
    chk("rmid_inst_rdata", inst_rdata, 0);
    chk("rmid_data_rdata", data_rdata, 0);
    chk("rmid_mem_en", 32'(mem_en), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    #3;
    chk("rrel_inst_rvalid", 32'(inst_rvalid), 0);
    @(posedge clk); #1;
    drive(1, 32'h100, 0, 0, 0, 0);
    #3;
    chk("rrel_inst_gnt", 32'(inst_gnt), 1);
    chk("rrel_mem_addr", mem_addr, 32'h100);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("rrel_rvalid", 32'(inst_rvalid), 1);
    chk("rrel_rdata", inst_rdata, 32'hDEADBEEF);
    chk("rrel_data_rvalid", 32'(data_rvalid), 0);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 256; i++)
      shadow[i] = sram[i];
    m_cnt = 0;
    m_pi = 0; m_pd = 0;
    m_piv = 0; m_pdv = 0; m_hi = 0; m_hd = 0;
    r_ir = 0; r_dr = 0;
    r_ia = 0; r_da = 0; r_dd = 0; r_dw = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (!r_ir && $urandom_range(0, 2) != 0) begin
        r_ir = 1;
        r_ia = 32'($urandom_range(0, 255)) << 2;
      end
      if (!r_dr && $urandom_range(0, 3) != 0) begin
        r_dr = 1;
        r_da = 32'($urandom_range(0, 255)) << 2;
        r_dd = $urandom;
        r_dw = ($urandom_range(0, 1) != 0) ? 4'h0
               : 4'($urandom_range(1, 15));
      end
      drive(r_ir, r_ia, r_dr, r_dw, r_da, r_dd);
      #3;
      ew_i = r_ir && (!r_dr || m_cnt == LIMIT);
      ew_d = r_dr && !ew_i;
      chk("rnd_inst_gnt", 32'(inst_gnt), 32'(ew_i));
      chk("rnd_data_gnt", 32'(data_gnt), 32'(ew_d));
      chk("rnd_mem_en", 32'(mem_en), 32'(ew_i | ew_d));
      chk("rnd_mem_wen", 32'(mem_wen), ew_d ? 32'(r_dw) : 0);
      if (ew_i || ew_d) begin
        chk("rnd_mem_addr", mem_addr, ew_i ? r_ia : r_da);
        chk("rnd_mem_wdata", mem_wdata, ew_i ? 32'h0 : r_dd);
      end
      chk("rnd_inst_rvalid", 32'(inst_rvalid), 32'(m_pi));
      chk("rnd_data_rvalid", 32'(data_rvalid), 32'(m_pd));
      chk("rnd_inst_rdata", inst_rdata, m_pi ? m_piv : m_hi);
      chk("rnd_data_rdata", data_rdata, m_pd ? m_pdv : m_hd);
      if (m_pi) m_hi = m_piv;
      if (m_pd) m_hd = m_pdv;
      m_pi  = ew_i;
      m_piv = shadow[r_ia[9:2]];
      m_pd  = ew_d && r_dw == 4'h0;
      m_pdv = shadow[r_da[9:2]];
      if (ew_d && r_dw != 4'h0) begin
        w = shadow[r_da[9:2]];
        for (int b = 0; b < 4; b++)
          if (r_dw[b]) w[8*b +: 8] = r_dd[8*b +: 8];
        shadow[r_da[9:2]] = w;
      end
      if (ew_i || !r_ir)
        m_cnt = 0;
      else if (m_cnt < LIMIT)
        m_cnt++;
      if (ew_i) r_ir = 0;
      if (ew_d) r_dr = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
